// File: rtl/button_pkg.sv
// button_pkg -- shared types and helpers for the pushbutton debouncer.
//   btn_state_t : debounce FSM state encoding
//   cnt_width() : bit width needed to hold the values 0..n
package button_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/button_debounce_sync_chain.sv
// sync_chain -- multi-flop synchronizer for an asynchronous 1-bit input.
//   clk : sampling clock
//   rst : synchronous active-high reset, loads RESET_VAL into every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module sync_chain #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= {STAGES{RESET_VAL}};
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// button_debounce -- debounces a pushbutton and issues a stretched reset request.
//   clk           : single clock, all flops on posedge
//   rst           : synchronous active-high reset
//   btn_raw       : asynchronous, bouncing pushbutton pin
//   btn_level     : debounced pressed level (1 = pressed)
//   press_pulse   : one-cycle strobe on each accepted press
//   release_pulse : one-cycle strobe on each accepted release
//   rst_req_n     : active-low reset request, held low while pressed and for
//                   at least MIN_ASSERT_CYCLES after an accepted press
module button_debounce
   import button_pkg::*;
#(
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned DEBOUNCE_CYCLES   = 16,
   parameter int unsigned MIN_ASSERT_CYCLES = 8,
   parameter bit          ACTIVE_LOW_IN     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic rst_req_n
);

   localparam int unsigned   DW        = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned   SW        = cnt_width(MIN_ASSERT_CYCLES);
   localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
   localparam logic [SW-1:0] ST_LOAD   = SW'(MIN_ASSERT_CYCLES);
   localparam logic          REL_LEVEL = ACTIVE_LOW_IN;

   logic          sync_q;
   logic          pressed;
   btn_state_t    state, state_nx;
   logic [DW-1:0] db_cnt, db_cnt_nx, db_inc;
   logic [SW-1:0] st_cnt, st_cnt_nx;
   logic          level_nx, press_nx, release_nx, rst_req_n_nx;

   sync_chain #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (REL_LEVEL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_raw),
      .q   (sync_q)
   );

   assign pressed = ACTIVE_LOW_IN ? ~sync_q : sync_q;

   // Saturating increment; db_cnt is 0 in the stable states, so the same
   // test lets DEBOUNCE_CYCLES == 1 accept straight from IDLE/PRESSED.
   assign db_inc = (db_cnt == DB_MAX) ? db_cnt : db_cnt + 1'b1;

   always_comb begin
      state_nx   = state;
      db_cnt_nx  = db_cnt;
      st_cnt_nx  = (st_cnt != '0) ? st_cnt - 1'b1 : st_cnt;
      press_nx   = 1'b0;
      release_nx = 1'b0;

      case (state)
         IDLE, PRESS_WAIT: begin
            if (pressed) begin
               if (db_inc == DB_MAX) begin
                  state_nx  = PRESSED;
                  db_cnt_nx = '0;
                  press_nx  = 1'b1;
                  st_cnt_nx = ST_LOAD;
               end else begin
                  state_nx  = PRESS_WAIT;
                  db_cnt_nx = db_inc;
               end
            end else begin
               state_nx  = IDLE;
               db_cnt_nx = '0;
            end
         end
         PRESSED, RELEASE_WAIT: begin
            if (!pressed) begin
               if (db_inc == DB_MAX) begin
                  state_nx   = IDLE;
                  db_cnt_nx  = '0;
                  release_nx = 1'b1;
               end else begin
                  state_nx  = RELEASE_WAIT;
                  db_cnt_nx = db_inc;
               end
            end else begin
               state_nx  = PRESSED;
               db_cnt_nx = '0;
            end
         end
         default: begin
            state_nx  = IDLE;
            db_cnt_nx = '0;
         end
      endcase

      // Outputs are derived from next-state values so they are registered
      // yet line up with the state they describe.
      level_nx     = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
      rst_req_n_nx = !(level_nx || (st_cnt_nx != '0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         db_cnt        <= '0;
         st_cnt        <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         rst_req_n     <= 1'b1;
      end else begin
         state         <= state_nx;
         db_cnt        <= db_cnt_nx;
         st_cnt        <= st_cnt_nx;
         btn_level     <= level_nx;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
         rst_req_n     <= rst_req_n_nx;
      end
   end

endmodule
